// File: rtl/elixirchip_es1_spu_checker_pkg.sv
// Shared definitions for the SPU NOP self-check monitor.
//   state_t                     : checker state machine encoding
//   sat_inc()                   : saturating increment for counters up to 32 bits
//   CHECKER_COUNT_BITS_DEFAULT  : default counter width
package elixirchip_es1_spu_checker_pkg;

  localparam int CHECKER_COUNT_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  // Increment value, sticking at the all-ones value of a width-bit counter.
  // Callers cast the result back to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_checker_model.sv
// Cycle-exact reference pipeline of the SPU NOP op.
// A hold register (stage 0) loads CLEAR_DATA on s_clear or s_data on s_valid,
// followed by LATENCY-1 delay stages; everything advances only on cke.
// A known bit travels with every stage so the checker can ignore the op's
// undefined power-up output until real data has reached the end of the line.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   cke                   : clock enable shared with the op
//   flush                 : synchronous clear of all stages and known bits
//   s_clear/s_data/s_valid: copy of the op inputs
//   exp, exp_known        : last stage value and its known bit
module elixirchip_es1_spu_checker_model #(
  parameter int  LATENCY    = 1,
  parameter type data_t     = logic [7:0],
  parameter data_t CLEAR_DATA = '1
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  cke,
  input  logic  flush,
  input  logic  s_clear,
  input  data_t s_data,
  input  logic  s_valid,
  output data_t exp,
  output logic  exp_known
);

  data_t              stage_q [LATENCY];
  logic [LATENCY-1:0] known_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
      known_q <= '0;
    end else if (flush) begin
      // Flush wins over cke so a disabled checker always restarts clean.
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
      known_q <= '0;
    end else if (cke) begin
      // Clear has priority over valid, matching the op.
      if (s_clear) begin
        stage_q[0] <= CLEAR_DATA;
      end else if (s_valid) begin
        stage_q[0] <= s_data;
      end
      known_q[0] <= known_q[0] | s_clear | s_valid;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
        known_q[i] <= known_q[i-1];
      end
    end
  end

  assign exp       = stage_q[LATENCY-1];
  assign exp_known = known_q[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_nop_checker.sv
// Self-check monitor for the SPU NOP op.
// Recomputes the op output with a reference pipeline, compares it with m_data on
// every enabled cycle, and keeps a sticky error flag, saturating error/compare
// counters and (optionally) a capture of the first failing compare.
// Optional feature macro: ELIXIRCHIP_SPU_CHECKER_FIRST_ERR_EN
//   defined   -> first_err_* capture the first mismatch after reset/err_clear
//   undefined -> capture registers are not built, first_err_* read 0
// Ports:
//   reset_n, clk, cke        : async active-low reset, clock, shared clock enable
//   enable                   : arms the checker (0 returns to IDLE, flushes model)
//   err_clear                : one-cycle clear of error status and counters
//   s_clear, s_data, s_valid : copy of the op inputs
//   m_data                   : op output under test
//   err, halted              : sticky mismatch flag, HALT state indicator
//   err_count, check_count   : saturating mismatch / compare counters
//   first_err_expected/actual/index : first-mismatch capture
module elixirchip_es1_spu_op_nop_checker
  import elixirchip_es1_spu_checker_pkg::*;
#(
  parameter int    LATENCY     = 1,
  parameter int    DATA_BITS   = 8,
  parameter type   data_t      = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA  = '1,
  parameter int    COUNT_BITS  = CHECKER_COUNT_BITS_DEFAULT,
  parameter int    STOP_ON_ERR = 0
) (
  input  logic                  reset_n,
  input  logic                  clk,
  input  logic                  cke,
  input  logic                  enable,
  input  logic                  err_clear,
  input  logic                  s_clear,
  input  data_t                 s_data,
  input  logic                  s_valid,
  input  data_t                 m_data,
  output logic                  err,
  output logic                  halted,
  output logic [COUNT_BITS-1:0] err_count,
  output logic [COUNT_BITS-1:0] check_count,
  output data_t                 first_err_expected,
  output data_t                 first_err_actual,
  output logic [COUNT_BITS-1:0] first_err_index
);

  localparam int                FILL_W    = $clog2(LATENCY + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);

  state_t                  state_q;
  logic [FILL_W-1:0]       fill_q;
  data_t                   exp;
  logic                    exp_known;
  logic                    cmp_en;
  logic                    mismatch;
  logic                    err_q, err_d;
  logic [COUNT_BITS-1:0]   err_count_q, err_count_d;
  logic [COUNT_BITS-1:0]   check_count_q, check_count_d;

  // The model runs whenever the checker is armed, including HALT, so it never
  // loses track of the op while compares are suspended.
  elixirchip_es1_spu_checker_model #(
    .LATENCY    (LATENCY),
    .data_t     (data_t),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_model (
    .clk       (clk),
    .reset_n   (reset_n),
    .cke       (cke),
    .flush     (~enable),
    .s_clear   (s_clear),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .exp       (exp),
    .exp_known (exp_known)
  );

  assign cmp_en   = enable && cke && (state_q == RUN) && exp_known;
  assign mismatch = cmp_en && (m_data != exp);

  // State machine. IDLE and FILL share the fill count: the edge that arms the
  // checker already advances the model, so it counts as the first fill cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      fill_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, FILL: begin
          if (cke) begin
            if (fill_q == FILL_LAST) begin
              state_q <= RUN;
            end else begin
              state_q <= FILL;
              fill_q  <= fill_q + 1'b1;
            end
          end else begin
            state_q <= FILL;
          end
        end
        RUN: begin
          // A mismatch dropped by err_clear must not halt either.
          if (mismatch && (STOP_ON_ERR != 0) && !err_clear) state_q <= HALT;
        end
        HALT: begin
          if (err_clear) begin
            state_q <= FILL;
            fill_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign halted = (state_q == HALT);

  always_comb begin
    err_d         = err_q;
    err_count_d   = err_count_q;
    check_count_d = check_count_q;
    if (err_clear) begin
      err_d         = 1'b0;
      err_count_d   = '0;
      check_count_d = '0;
    end else if (cmp_en) begin
      check_count_d = COUNT_BITS'(sat_inc(32'(check_count_q), COUNT_BITS));
      if (mismatch) begin
        err_d       = 1'b1;
        err_count_d = COUNT_BITS'(sat_inc(32'(err_count_q), COUNT_BITS));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q         <= 1'b0;
      err_count_q   <= '0;
      check_count_q <= '0;
    end else begin
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      check_count_q <= check_count_d;
    end
  end

  assign err         = err_q;
  assign err_count   = err_count_q;
  assign check_count = check_count_q;

`ifdef ELIXIRCHIP_SPU_CHECKER_FIRST_ERR_EN
  data_t                 fe_exp_q;
  data_t                 fe_act_q;
  logic [COUNT_BITS-1:0] fe_idx_q;

  // err_q low means no mismatch has been seen since reset or err_clear, so
  // this mismatch is the first one. The index is the compare count before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fe_exp_q <= '0;
      fe_act_q <= '0;
      fe_idx_q <= '0;
    end else if (err_clear) begin
      fe_exp_q <= '0;
      fe_act_q <= '0;
      fe_idx_q <= '0;
    end else if (mismatch && !err_q) begin
      fe_exp_q <= exp;
      fe_act_q <= m_data;
      fe_idx_q <= check_count_q;
    end
  end

  assign first_err_expected = fe_exp_q;
  assign first_err_actual   = fe_act_q;
  assign first_err_index    = fe_idx_q;
`else
  assign first_err_expected = '0;
  assign first_err_actual   = '0;
  assign first_err_index    = '0;
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_nop_checker.sv
// Bench for elixirchip_es1_spu_op_nop_checker. Two instances share one stimulus:
//   A: LATENCY=3, COUNT_BITS=4,  STOP_ON_ERR=0 (saturation)
//   B: LATENCY=3, COUNT_BITS=16, STOP_ON_ERR=1 (halt behaviour)
// The bench plays the monitored op itself: m_data is the NOP output derived
// from the history of loaded values, optionally overridden to inject faults.
module tb_elixirchip_es1_spu_op_nop_checker;

  localparam int          L     = 3;
  localparam logic [7:0]  CLR_V = 8'hFF;
`ifdef ELIXIRCHIP_SPU_CHECKER_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, cke, enable, err_clear, s_clear, s_valid;
  logic [7:0] s_data, m_data;

  logic        err_a, halted_a, err_b, halted_b;
  logic [3:0]  ecnt_a, ccnt_a, fix_a;
  logic [15:0] ecnt_b, ccnt_b, fix_b;
  logic [7:0]  fex_a, fac_a, fex_b, fac_b;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_nop_checker #(.LATENCY(L), .COUNT_BITS(4), .STOP_ON_ERR(0)) u_a (
    .reset_n(reset_n), .clk(clk), .cke(cke), .enable(enable), .err_clear(err_clear),
    .s_clear(s_clear), .s_data(s_data), .s_valid(s_valid), .m_data(m_data),
    .err(err_a), .halted(halted_a), .err_count(ecnt_a), .check_count(ccnt_a),
    .first_err_expected(fex_a), .first_err_actual(fac_a), .first_err_index(fix_a));

  elixirchip_es1_spu_op_nop_checker #(.LATENCY(L), .COUNT_BITS(16), .STOP_ON_ERR(1)) u_b (
    .reset_n(reset_n), .clk(clk), .cke(cke), .enable(enable), .err_clear(err_clear),
    .s_clear(s_clear), .s_data(s_data), .s_valid(s_valid), .m_data(m_data),
    .err(err_b), .halted(halted_b), .err_count(ecnt_b), .check_count(ccnt_b),
    .first_err_expected(fex_b), .first_err_actual(fac_b), .first_err_index(fix_b));

  // ---------------- behavioural model ----------------
  // n counts cke edges since the checker was armed; hist[k] is the op's hold
  // value after edge k. A compare at edge n sees hist[n-L], and is possible
  // once the first load (edge first_load) is L edges old and the checker has
  // had L cke edges of fill since arming or leaving HALT (resume_at).
  int         n, first_load;
  logic [7:0] hold;
  logic [7:0] hist[$];
  int         resume_at[2];
  bit         halt_m[2], err_m[2];
  int         errc_m[2], chkc_m[2], fe_idx_m[2];
  logic [7:0] fe_exp_m[2], fe_act_m[2];
  int         cmax[2]   = '{15, 65535};
  bit         stop_m[2] = '{1'b0, 1'b1};

  task automatic clear_stats(input int i);
    err_m[i] = 1'b0; errc_m[i] = 0; chkc_m[i] = 0;
    fe_exp_m[i] = 8'h00; fe_act_m[i] = 8'h00; fe_idx_m[i] = 0;
  endtask

  task automatic model_disarm();
    n = 0; first_load = 0; hold = 8'h00;
    hist.delete(); hist.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin halt_m[i] = 1'b0; resume_at[i] = L + 1; end
  endtask

  task automatic model_reset();
    model_disarm();
    for (int i = 0; i < 2; i++) clear_stats(i);
  endtask

  function automatic logic [7:0] ref_out(input bit en, input bit ck);
    int nn;
    nn = n + ((en && ck) ? 1 : 0);
    if (en && first_load != 0 && nn - L >= first_load) return hist[nn-L];
    return 8'($urandom);
  endfunction

  task automatic model_edge(input bit en, input bit ck, input bit clr, input bit vld,
                            input logic [7:0] d, input bit ec, input logic [7:0] md);
    int nn;
    bit cmp, mis;
    if (!en) begin
      model_disarm();
      if (ec) for (int i = 0; i < 2; i++) clear_stats(i);
    end else begin
      nn = n + (ck ? 1 : 0);
      for (int i = 0; i < 2; i++) begin
        cmp = ck && !halt_m[i] && first_load != 0 && nn >= first_load + L && nn >= resume_at[i];
        mis = 1'b0;
        if (cmp) mis = (md != hist[nn-L]);
        if (ec) begin
          clear_stats(i);
          if (halt_m[i]) begin halt_m[i] = 1'b0; resume_at[i] = nn + L + 1; end
        end else if (cmp) begin
          if (mis && !err_m[i]) begin
            fe_idx_m[i] = chkc_m[i]; fe_exp_m[i] = hist[nn-L]; fe_act_m[i] = md;
          end
          chkc_m[i] = (chkc_m[i] < cmax[i]) ? chkc_m[i] + 1 : cmax[i];
          if (mis) begin
            err_m[i]  = 1'b1;
            errc_m[i] = (errc_m[i] < cmax[i]) ? errc_m[i] + 1 : cmax[i];
            if (stop_m[i]) halt_m[i] = 1'b1;
          end
        end
      end
      if (ck) begin
        n = nn;
        if (clr) hold = CLR_V;
        else if (vld) hold = d;
        if ((clr || vld) && first_load == 0) first_load = nn;
        hist.push_back(hold);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("err_a",      int'(err_a),    int'(err_m[0]));
      chk("halted_a",   int'(halted_a), int'(halt_m[0]));
      chk("err_count_a", int'(ecnt_a),  errc_m[0]);
      chk("check_count_a", int'(ccnt_a), chkc_m[0]);
      chk("fe_exp_a",   int'(fex_a), FE_EN ? int'(fe_exp_m[0]) : 0);
      chk("fe_act_a",   int'(fac_a), FE_EN ? int'(fe_act_m[0]) : 0);
      chk("fe_idx_a",   int'(fix_a), FE_EN ? fe_idx_m[0] : 0);
      chk("err_b",      int'(err_b),    int'(err_m[1]));
      chk("halted_b",   int'(halted_b), int'(halt_m[1]));
      chk("err_count_b", int'(ecnt_b),  errc_m[1]);
      chk("check_count_b", int'(ccnt_b), chkc_m[1]);
      chk("fe_exp_b",   int'(fex_b), FE_EN ? int'(fe_exp_m[1]) : 0);
      chk("fe_act_b",   int'(fac_b), FE_EN ? int'(fe_act_m[1]) : 0);
      chk("fe_idx_b",   int'(fix_b), FE_EN ? fe_idx_m[1] : 0);
    end
  end

  // ---------------- stimulus ----------------
  // inj < 0: op output; inj == 256: inverted op output; else forced value.
  task automatic step(input bit en, input bit ck, input bit clr, input bit vld,
                      input logic [7:0] d, input bit ec, input int inj);
    logic [7:0] ref_v;
    ref_v = ref_out(en, ck);
    enable = en; cke = ck; s_clear = clr; s_valid = vld; s_data = d; err_clear = ec;
    if (inj < 0)         m_data = ref_v;
    else if (inj == 256) m_data = ~ref_v;
    else                 m_data = 8'(inj);
    @(posedge clk);
    model_edge(en, ck, clr, vld, d, ec, m_data);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    reset_n = 1'b0; cke = 1'b0; enable = 1'b0; err_clear = 1'b0;
    s_clear = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_data = 8'h00;
    model_reset();
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_err_a", int'(err_a), 0);
    chk("reset_check_count_b", int'(ccnt_b), 0);
    chk("reset_halted_b", int'(halted_b), 0);
    reset_n = 1'b1;

    // Disarmed: inputs are ignored.
    step(0, 1, 0, 1, 8'h77, 0, -1);
    step(0, 1, 1, 0, 8'h00, 0, -1);

    // Armed, nothing loaded yet: op output is undefined, no compares.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 8'h00, 0, -1);
    chk("no_cmp_before_load", int'(ccnt_b), 0);

    // Clear and valid together: clear wins, 0xFF expected L edges later.
    step(1, 1, 1, 1, 8'h12, 0, -1);
    step(1, 1, 0, 0, 8'h00, 0, -1);
    step(1, 1, 0, 0, 8'h00, 0, -1);
    step(1, 1, 0, 0, 8'h00, 0, 8'hFF);
    chk("clear_prio_count", int'(ccnt_b), 1);
    chk("clear_prio_err", int'(err_b), 0);

    // Load 0xAA and corrupt its compare with 0x55.
    step(1, 1, 0, 1, 8'hAA, 0, -1);
    step(1, 1, 0, 0, 8'h00, 0, -1);
    step(1, 1, 0, 0, 8'h00, 0, -1);
    step(1, 1, 0, 0, 8'h00, 0, 8'h55);
    chk("inj1_err_count_a", int'(ecnt_a), 1);
    chk("inj1_err_a", int'(err_a), 1);
    chk("inj1_err_count_b", int'(ecnt_b), 1);
    chk("inj1_halted_b", int'(halted_b), 1);
    chk("inj1_fe_exp_b", int'(fex_b), FE_EN ? 8'hAA : 0);
    chk("inj1_fe_act_b", int'(fac_b), FE_EN ? 8'h55 : 0);
    chk("inj1_fe_idx_a", int'(fix_a), FE_EN ? 4 : 0);
    step(1, 1, 0, 0, 8'h00, 0, 8'h55);
    chk("inj2_err_count_a", int'(ecnt_a), 2);
    chk("inj2_err_count_b", int'(ecnt_b), 1);
    chk("inj2_halted_b", int'(halted_b), 1);

    // err_clear leaves HALT for FILL: B skips L cke edges before comparing.
    step(1, 1, 0, 0, 8'h00, 1, -1);
    chk("clr_err_count_a", int'(ecnt_a), 0);
    chk("clr_check_count_a", int'(ccnt_a), 0);
    chk("clr_err_count_b", int'(ecnt_b), 0);
    chk("clr_halted_b", int'(halted_b), 0);
    chk("clr_err_b", int'(err_b), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'h00, 0, -1);
    chk("fill_check_count_a", int'(ccnt_a), 3);
    chk("fill_check_count_b", int'(ccnt_b), 0);
    step(1, 1, 0, 0, 8'h00, 0, -1);
    chk("resume_check_count_b", int'(ccnt_b), 1);

    // Random traffic, cke high about 90% of the time.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 2))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      step(1, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, d, 0, -1);
    end
    chk("random_err_a", int'(err_a), 0);
    chk("random_err_b", int'(err_b), 0);
    chk("random_cmp_seen_b", int'(ccnt_b != 16'd0), 1);

    // Disarm and re-arm: counters kept, model restarts empty.
    step(0, 1, 0, 1, 8'h21, 0, -1);
    step(0, 0, 0, 0, 8'h00, 0, -1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 8'(8'h30 + i), 0, -1);

    // Continuous mismatches: A saturates at 15, B halts after one.
    for (int i = 0; i < 25; i++) step(1, 1, 0, 0, 8'h00, 0, 256);
    chk("sat_err_count_a", int'(ecnt_a), 15);
    chk("sat_halted_b", int'(halted_b), 1);

    // Asynchronous reset in the middle of a run.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_err_count_a", int'(ecnt_a), 0);
    chk("async_check_count_a", int'(ccnt_a), 0);
    chk("async_err_a", int'(err_a), 0);
    chk("async_halted_b", int'(halted_b), 0);
    chk("async_fe_act_b", int'(fac_b), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // After reset, no compares until something is loaded.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 8'h00, 0, -1);
    chk("post_reset_no_cmp_a", int'(ccnt_a), 0);
    chk("post_reset_no_cmp_b", int'(ccnt_b), 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
